// File: rtl/branch_operand_hazard_unit.sv
// branch_operand_hazard_unit
//   Producer-side hazard control for the ID-stage equality comparator used for
//   early branch resolution. A two-slot shadow pipeline (EX, MEM) tracks
//   in-flight register writers. For each comparator operand the unit chooses
//   one of three sources: the register file, the MEM-stage ALU result
//   (fwd_a / fwd_b), or a stall of ID. It also flags ordinary load-use hazards
//   for non-branch instructions.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_is_branch                ID instruction is beq/bne
//   id_uses_rs / id_uses_rt     ID instruction reads rs / rt
//   id_rs / id_rt               source register specifiers
//   id_writes_reg, id_dest      ID instruction writes id_dest
//   id_is_load                  ID instruction is lw
//   stall                       hold PC and IF/ID, bubble into EX
//   fwd_a / fwd_b               comparator operand takes MEM ALU result
//   stall_count                 saturating count of stall cycles since reset
module branch_operand_hazard_unit #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_is_branch,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_writes_reg,
  input  logic [REGW-1:0] id_dest,
  input  logic            id_is_load,
  output logic            stall,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic [CNTW-1:0] stall_count
);

  // Shadow slots; WB is not tracked because the register file is write-first.
  logic            ex_v, ex_ld, mem_v, mem_ld;
  logic [REGW-1:0] ex_dest, mem_dest;

  logic ex_a, ex_b, mem_a, mem_b;
  logic ex_any, mem_ld_any;

  always_comb begin
    // $0 never hazards and an unused operand never matches.
    ex_a  = ex_v  && (ex_dest  == id_rs) && (id_rs != '0) && id_uses_rs;
    ex_b  = ex_v  && (ex_dest  == id_rt) && (id_rt != '0) && id_uses_rt;
    mem_a = mem_v && (mem_dest == id_rs) && (id_rs != '0) && id_uses_rs;
    mem_b = mem_v && (mem_dest == id_rt) && (id_rt != '0) && id_uses_rt;

    ex_any     = ex_a | ex_b;
    mem_ld_any = mem_ld & (mem_a | mem_b);

    // A branch stalls on any EX match: an ALU writer needs one cycle to reach
    // MEM, a load needs one more (EX match, then MEM-load match). Non-branch
    // instructions forward from the later stages and only stall on load-use.
    stall = id_valid & (( id_is_branch & (ex_any | mem_ld_any)) |
                        (~id_is_branch & ex_ld & ex_any));

    // An EX match always stalls, so suppressing forwarding under stall also
    // gives the younger writer priority over MEM.
    fwd_a = id_valid & id_is_branch & ~stall & mem_a & ~mem_ld;
    fwd_b = id_valid & id_is_branch & ~stall & mem_b & ~mem_ld;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v        <= 1'b0;
      ex_dest     <= '0;
      ex_ld       <= 1'b0;
      mem_v       <= 1'b0;
      mem_dest    <= '0;
      mem_ld      <= 1'b0;
      stall_count <= '0;
    end else begin
      mem_v    <= ex_v;
      mem_dest <= ex_dest;
      mem_ld   <= ex_ld;
      if (stall) begin
        ex_v    <= 1'b0;
        ex_dest <= '0;
        ex_ld   <= 1'b0;
      end else begin
        ex_v    <= id_valid & id_writes_reg & (id_dest != '0);
        ex_dest <= id_dest;
        ex_ld   <= id_is_load;
      end
      if (stall && (stall_count != {CNTW{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_operand_hazard_unit.sv
module tb_branch_operand_hazard_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_is_branch, id_uses_rs, id_uses_rt;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_writes_reg, id_is_load;
  logic       stall, fwd_a, fwd_b;
  logic [15:0] stall_count;
  logic       stall2, fwd_a2, fwd_b2;
  logic [1:0] stall_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_operand_hazard_unit #(.REGW(5), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_writes_reg(id_writes_reg), .id_dest(id_dest), .id_is_load(id_is_load),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  branch_operand_hazard_unit #(.REGW(5), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_writes_reg(id_writes_reg), .id_dest(id_dest), .id_is_load(id_is_load),
    .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(stall_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive the ID stage; called just after a rising edge.
  task automatic set_id(input logic v, input logic br, input logic urs, input logic urt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic wr,
                        input logic [4:0] dest, input logic ld);
    id_valid = v; id_is_branch = br; id_uses_rs = urs; id_uses_rt = urt;
    id_rs = rs; id_rt = rt; id_writes_reg = wr; id_dest = dest; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic adv();  // rising edge, then settle
    @(posedge clk); #1;
  endtask

  task automatic smp();  // sample away from the active edge
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    adv(); adv();
    reset = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic s, input logic fa, input logic fb);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
    chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Reset state
    do_reset();
    smp();
    chk_out("reset", 0, 0, 0);
    chk("reset.count", 32'(stall_count), 0);

    // ALU forward to branch: add $8 ; beq $8,$9
    do_reset();
    set_id(1, 0, 1, 1, 1, 2, 1, 8, 0);
    smp(); chk_out("alu.add", 0, 0, 0);
    adv();
    set_id(1, 1, 1, 1, 8, 9, 0, 0, 0);
    smp(); chk_out("alu.beq1", 1, 0, 0);
    adv();
    smp(); chk_out("alu.beq2", 0, 1, 0);
    chk("alu.count", 32'(stall_count), 1);
    adv(); idle();

    // Load feeding a branch: lw $8 ; beq $9,$8
    do_reset();
    set_id(1, 0, 1, 0, 1, 0, 1, 8, 1);
    adv();
    set_id(1, 1, 1, 1, 9, 8, 0, 0, 0);
    smp(); chk_out("ldbr.c1", 1, 0, 0);
    adv();
    smp(); chk_out("ldbr.c2", 1, 0, 0);
    adv();
    smp(); chk_out("ldbr.c3", 0, 0, 0);
    chk("ldbr.count", 32'(stall_count), 2);
    adv(); idle();

    // Load-use on a non-branch: lw $5 ; add rs=$5
    do_reset();
    set_id(1, 0, 1, 0, 1, 0, 1, 5, 1);
    adv();
    set_id(1, 0, 1, 1, 5, 6, 1, 10, 0);
    smp(); chk_out("lduse.c1", 1, 0, 0);
    adv();
    smp(); chk_out("lduse.c2", 0, 0, 0);
    chk("lduse.count", 32'(stall_count), 1);
    adv(); idle();

    // $0 immunity: add $0 ; beq $0,$0
    do_reset();
    set_id(1, 0, 1, 1, 1, 2, 1, 0, 0);
    adv();
    set_id(1, 1, 1, 1, 0, 0, 0, 0, 0);
    smp(); chk_out("zero.c1", 0, 0, 0);
    adv();
    smp(); chk_out("zero.c2", 0, 0, 0);
    adv();
    // No-use immunity: lw $7 ; instr with rs=$7 but uses_rs=0
    set_id(1, 0, 1, 0, 1, 0, 1, 7, 1);
    adv();
    set_id(1, 0, 0, 1, 7, 3, 1, 9, 0);
    smp(); chk_out("nouse.alu", 0, 0, 0);
    set_id(1, 1, 0, 1, 7, 3, 0, 0, 0);
    smp(); chk_out("nouse.br", 0, 0, 0);
    chk("nouse.count", 32'(stall_count), 0);
    adv(); idle();

    // EX vs MEM priority: add $3 ; add $3 ; beq $3,$4
    do_reset();
    set_id(1, 0, 1, 1, 1, 2, 1, 3, 0);
    adv();
    set_id(1, 0, 1, 1, 1, 2, 1, 3, 0);
    adv();
    set_id(1, 1, 1, 1, 3, 4, 0, 0, 0);
    smp(); chk_out("prio.c1", 1, 0, 0);
    adv();
    smp(); chk_out("prio.c2", 0, 1, 0);
    adv(); idle();

    // Reset during the 2nd stall of lw->beq
    do_reset();
    set_id(1, 0, 1, 0, 1, 0, 1, 8, 1);
    adv();
    set_id(1, 1, 1, 1, 9, 8, 0, 0, 0);
    adv();
    smp(); chk_out("rstmid.c2", 1, 0, 0);
    chk("rstmid.count1", 32'(stall_count), 1);
    reset = 1'b1;
    adv();
    reset = 1'b0;
    smp(); chk_out("rstmid.after", 0, 0, 0);
    chk("rstmid.count0", 32'(stall_count), 0);
    adv(); idle();

    // Saturation: three lw->beq pairs give 6 stalls; CNTW=2 holds at 3
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_id(1, 0, 1, 0, 1, 0, 1, 8, 1);
      adv();
      set_id(1, 1, 1, 1, 9, 8, 0, 0, 0);
      adv(); adv();
      if (k == 1) begin
        smp();
        chk("sat.mid16", 32'(stall_count), 4);
        chk("sat.mid2", 32'(stall_count2), 3);
      end
    end
    smp();
    chk("sat.count16", 32'(stall_count), 6);
    chk("sat.count2", 32'(stall_count2), 3);
    chk("sat.stall2", 32'(stall2), 0);
    idle();
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
